gcl_ram_ctrl: RTL
=================

// Module: gcl_ram_ctrl
// PURPOSE
//  GCL table owner and read responder. Loads the 32-entry x 128-bit gate control list from the management
//  path as 32-bit words and serves gate-control-module reads with fixed 2-cycle latency.
//  Asserts lau_update_finish once a full table load has committed.
//  Sits between the LCM config path and the gate control module.
// PARAMETERS
//  PLATFORM    "xilinx"  RAM primitive selection, passed to gcl_ram_sdp
//  GCL_DEPTH   32        entries; address width 5
//  GCL_WIDTH   128       bits per entry: 16 slots x 8 queues
// PORTS
//  clk                  in   1    clock
//  rst_n                in   1    asynchronous active-low reset
//  cfg_load_start       in   1    pulse; opens a table load
//  cfg_wr               in   1    pulse; write cfg_wdata to cfg_addr
//  cfg_addr             in   7    [6:2] entry, [1:0] word (word0 = bits 31:0)
//  cfg_wdata            in   32   config write data
//  cfg_rd               in   1    pulse; config read-back request
//  cfg_rdata            out  32   read-back word
//  cfg_rdata_valid      out  1    1-cycle strobe with cfg_rdata
//  cfg_err_cnt          out  8    dropped/illegal config writes, saturating
//  lau_update_finish    out  1    level; table valid and readable by GCM
//  in_gcl_rd            in   1    GCM read request, held >=1 cycle
//  in_gcl_addr          in   5    GCM read entry
//  out_gcl_gc           out  128  entry data; held until next read
//  gcl_parity_err       out  1    sticky; only with GCL_PARITY_EN
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, staging and error count cleared. RAM contents undefined.
//  FSM: IDLE -(cfg_load_start)-> LOADING -(entry 31 word 3 committed)-> READY.
//       READY -(cfg_load_start)-> LOADING.
//   - lau_update_finish = (state==READY).
//   - cfg_load_start while LOADING restarts the load: staging mask cleared.
//  Load write: cfg_wr in LOADING stores the word into the 128-bit staging register and sets mask bit [1:0].
//   - Writing word 3 commits staging to RAM at entry [6:2] in the next cycle, then clears the mask.
//   - A commit with mask != 4'b1111 is still performed and cfg_err_cnt++ (incomplete entry).
//   - cfg_wr outside LOADING is dropped and cfg_err_cnt++. cfg_err_cnt saturates at 255.
//  GCM read: the rising edge of in_gcl_rd samples in_gcl_addr.
//   - RAM output is registered: out_gcl_gc is valid 2 cycles after the rising edge.
//   - out_gcl_gc holds until the next rising edge.
//   - Holding rd high does not re-read.
//   - Reads are served in any state; in non-READY states the data is whatever the RAM holds.
//  Read-back: cfg_rd is queued as 1 pending request.
//   - It is served on the RAM read port only in cycles where no GCM read edge occurs; GCM has priority.
//   - cfg_rdata_valid fires 2 cycles after issue.
//   - A second cfg_rd while one is pending is dropped and cfg_err_cnt++.
//   - Read-back never disturbs out_gcl_gc.
//  Simultaneous commit and GCM read of the same entry returns the old data (read-first).
//  rst_n low mid-load returns to IDLE and drops lau_update_finish.
// CONFIGURATION
//  GCL_PARITY_EN defined:
//   - RAM widens to 144 bits, with 1 even-parity bit per 8-bit slot computed at commit.
//   - Parity is checked when out_gcl_gc updates; a mismatch sets gcl_parity_err.
//   - gcl_parity_err is cleared by cfg_load_start or reset.
//  GCL_PARITY_EN undefined: 128-bit RAM; gcl_parity_err tied 0.
// STRUCTURE
//  gcl_pkg: GCL_DEPTH, GCL_WIDTH, GCL_AW, slot width 8, FSM state localparams, cfg address field offsets.
//  Sub-module gcl_ram_sdp: simple dual-port, 1 write port and 1 registered read port, PLATFORM-selected.
//  Staging, FSM, arbitration and parity stay in gcl_ram_ctrl.
// TESTING
//  1. Load start, 128 words (entry i word w = {i,w,24'hA5A5A5}).
//     -> lau_update_finish=1 one cycle after the final commit; read-back of all 128 words matches.
//  2. READY, in_gcl_rd held 3 cycles with addr 5.
//     -> out_gcl_gc = entry 5 exactly 2 cycles after the edge; stable afterwards.
//  3. cfg_wr in IDLE, then entry 3 word 3 written alone in LOADING.
//     -> cfg_err_cnt=2 and entry 3 committed.
//  4. cfg_rd issued in the same cycle as a GCM read edge.
//     -> GCM data at +2 cycles, cfg_rdata_valid at +3; out_gcl_gc unchanged by read-back.
//  5. rst_n pulsed during the load of entry 20.
//     -> lau_update_finish=0, state IDLE, cfg_err_cnt=0.
//  6. (GCL_PARITY_EN) Force a flipped bit in RAM entry 7, then GCM read 7.
//     -> gcl_parity_err=1 at +2 cycles; cleared by cfg_load_start.

Source files
------------

// File: rtl/gcl_pkg.sv
// Shared constants and FSM state type for the gate control list RAM controller.
// GCL_PARITY_EN (optional) widens stored entries with one even-parity bit per 8-bit slot.
package gcl_pkg;

    localparam int GCL_DEPTH     = 32;
    localparam int GCL_WIDTH     = 128;
    localparam int GCL_AW        = $clog2(GCL_DEPTH);
    localparam int GCL_SLOT_W    = 8;
    localparam int CFG_WORD_W    = 32;
    localparam int CFG_ENTRY_LSB = 2;
    localparam int CFG_AW        = GCL_AW + CFG_ENTRY_LSB;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOADING = 2'd1,
        ST_READY   = 2'd2
    } gcl_state_t;

endpackage

// File: rtl/gcl_ram_sdp.sv
// Simple dual-port RAM: one write port, one registered read port (read-first on collision).
// PLATFORM selects the vendor attribute attached to the storage array.
module gcl_ram_sdp #(
    parameter     PLATFORM = "xilinx",
    parameter int DEPTH    = 32,
    parameter int WIDTH    = 128,
    parameter int AW       = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    generate
        if (PLATFORM == "xilinx") begin : g_xilinx
            (* ram_style = "block" *) logic [WIDTH-1:0] mem [DEPTH];

            always_ff @(posedge clk) begin
                if (we)
                    mem[waddr] <= wdata;
                if (re)
                    rdata <= mem[raddr];
            end
        end else begin : g_generic
            logic [WIDTH-1:0] mem [DEPTH];

            always_ff @(posedge clk) begin
                if (we)
                    mem[waddr] <= wdata;
                if (re)
                    rdata <= mem[raddr];
            end
        end
    endgenerate

endmodule

// File: rtl/gcl_ram_ctrl.sv
// GCL table owner: stages 32-bit config words into 128-bit entries, commits them to RAM and
// serves GCM reads and config read-back from one read port. Optional macro: GCL_PARITY_EN.
module gcl_ram_ctrl
    import gcl_pkg::*;
#(
    parameter     PLATFORM  = "xilinx",
    parameter int GCL_DEPTH = gcl_pkg::GCL_DEPTH,
    parameter int GCL_WIDTH = gcl_pkg::GCL_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           cfg_load_start,
    input  logic                           cfg_wr,
    input  logic [$clog2(GCL_DEPTH)+1:0]   cfg_addr,
    input  logic [31:0]                    cfg_wdata,
    input  logic                           cfg_rd,
    output logic [31:0]                    cfg_rdata,
    output logic                           cfg_rdata_valid,
    output logic [7:0]                     cfg_err_cnt,
    output logic                           lau_update_finish,
    input  logic                           in_gcl_rd,
    input  logic [$clog2(GCL_DEPTH)-1:0]   in_gcl_addr,
    output logic [GCL_WIDTH-1:0]           out_gcl_gc,
    output logic                           gcl_parity_err
);

    localparam int AW = $clog2(GCL_DEPTH);
`ifdef GCL_PARITY_EN
    localparam int SLOTS = GCL_WIDTH / GCL_SLOT_W;
    localparam int RAM_W = GCL_WIDTH + SLOTS;
`else
    localparam int RAM_W = GCL_WIDTH;
`endif

    gcl_state_t            state_reg;
    logic [GCL_WIDTH-1:0]  staging_reg;
    logic [3:0]            mask_reg;
    logic                  commit_reg;
    logic [AW-1:0]         commit_addr_reg;
    logic [7:0]            err_cnt_reg;
    logic                  rd_d_reg;
    logic                  pend_reg;
    logic [AW+1:0]         pend_addr_reg;
    logic                  src_gcm_reg;
    logic                  src_cfg_reg;
    logic [1:0]            word_reg;

    logic [AW-1:0]         cfg_entry;
    logic [1:0]            cfg_word;
    logic                  wr_ok, wr_drop, rd_drop, last_word, incomplete;
    logic                  gcm_edge, cfg_req, cfg_issue;
    logic [AW+1:0]         cfg_rd_addr;
    logic [8:0]            err_sum;
    logic [7:0]            err_next;
    logic                  ram_re;
    logic [AW-1:0]         ram_raddr;
    logic [RAM_W-1:0]      ram_wdata;
    logic [RAM_W-1:0]      ram_q;

    assign cfg_entry  = cfg_addr[AW+1:CFG_ENTRY_LSB];
    assign cfg_word   = cfg_addr[1:0];
    assign wr_ok      = cfg_wr & (state_reg == ST_LOADING);
    assign wr_drop    = cfg_wr & (state_reg != ST_LOADING);
    assign last_word  = (cfg_word == 2'd3);
    assign incomplete = wr_ok & last_word & ((mask_reg | 4'b1000) != 4'b1111);

    // GCM read edges own the read port; a config read waits in a single-entry pending slot.
    assign gcm_edge    = in_gcl_rd & ~rd_d_reg;
    assign cfg_req     = cfg_rd | pend_reg;
    assign cfg_issue   = cfg_req & ~gcm_edge;
    assign rd_drop     = cfg_rd & pend_reg;
    assign cfg_rd_addr = pend_reg ? pend_addr_reg : cfg_addr;
    assign ram_re      = gcm_edge | cfg_issue;
    assign ram_raddr   = gcm_edge ? in_gcl_addr : cfg_rd_addr[AW+1:CFG_ENTRY_LSB];

    assign err_sum  = {1'b0, err_cnt_reg} + {8'd0, wr_drop | incomplete} + {8'd0, rd_drop};
    assign err_next = err_sum[8] ? 8'hFF : err_sum[7:0];

    assign cfg_err_cnt       = err_cnt_reg;
    assign lau_update_finish = (state_reg == ST_READY);

`ifdef GCL_PARITY_EN
    logic [SLOTS-1:0] wr_par;
    logic [SLOTS-1:0] rd_par;
    logic             parity_err_reg;

    for (genvar gi = 0; gi < SLOTS; gi++) begin : g_par
        assign wr_par[gi] = ^staging_reg[gi*GCL_SLOT_W +: GCL_SLOT_W];
        assign rd_par[gi] = ^ram_q[gi*GCL_SLOT_W +: GCL_SLOT_W];
    end

    assign ram_wdata      = {wr_par, staging_reg};
    assign gcl_parity_err = parity_err_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            parity_err_reg <= 1'b0;
        else if (cfg_load_start)
            parity_err_reg <= 1'b0;
        else if (src_gcm_reg && (rd_par != ram_q[RAM_W-1:GCL_WIDTH]))
            parity_err_reg <= 1'b1;
    end
`else
    assign ram_wdata      = staging_reg;
    assign gcl_parity_err = 1'b0;
`endif

    gcl_ram_sdp #(
        .PLATFORM (PLATFORM),
        .DEPTH    (GCL_DEPTH),
        .WIDTH    (RAM_W),
        .AW       (AW)
    ) u_ram (
        .clk   (clk),
        .we    (commit_reg),
        .waddr (commit_addr_reg),
        .wdata (ram_wdata),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            staging_reg     <= '0;
            mask_reg        <= '0;
            commit_reg      <= 1'b0;
            commit_addr_reg <= '0;
            err_cnt_reg     <= '0;
            rd_d_reg        <= 1'b0;
            pend_reg        <= 1'b0;
            pend_addr_reg   <= '0;
            src_gcm_reg     <= 1'b0;
            src_cfg_reg     <= 1'b0;
            word_reg        <= '0;
        end else begin
            if (cfg_load_start)
                state_reg <= ST_LOADING;
            else if (state_reg == ST_LOADING && commit_reg &&
                     commit_addr_reg == AW'(GCL_DEPTH - 1))
                state_reg <= ST_READY;

            if (wr_ok) begin
                staging_reg[cfg_word*CFG_WORD_W +: CFG_WORD_W] <= cfg_wdata;
                mask_reg        <= last_word ? 4'b0000 : (mask_reg | (4'b0001 << cfg_word));
                commit_addr_reg <= cfg_entry;
            end
            if (cfg_load_start)
                mask_reg <= 4'b0000;

            commit_reg  <= wr_ok & last_word;
            err_cnt_reg <= err_next;

            rd_d_reg <= in_gcl_rd;
            pend_reg <= cfg_req & ~cfg_issue;
            if (cfg_rd && !pend_reg)
                pend_addr_reg <= cfg_addr;

            src_gcm_reg <= gcm_edge;
            src_cfg_reg <= cfg_issue;
            word_reg    <= cfg_rd_addr[1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_gcl_gc      <= '0;
            cfg_rdata       <= '0;
            cfg_rdata_valid <= 1'b0;
        end else begin
            if (src_gcm_reg)
                out_gcl_gc <= ram_q[GCL_WIDTH-1:0];
            cfg_rdata_valid <= src_cfg_reg;
            if (src_cfg_reg)
                cfg_rdata <= ram_q[word_reg*CFG_WORD_W +: CFG_WORD_W];
        end
    end

endmodule
